// File: rtl/mrr_sfo_fft_shift_apply_pkg.sv
// Shared widths and helpers for the SFO/CFO FFT shift-apply path.
// Optional rounding is enabled by defining MRR_SFO_SHIFT_ROUND_EN.
package mrr_sfo_fft_shift_apply_pkg;

    localparam int PRIMARY_FFT_MAX_LEN_LOG2 = 10;
    localparam int SFO_IN_WIDTH             = 32;
    localparam int SFO_OUT_WIDTH            = 16;
    localparam int SFO_SHIFT_WIDTH          = 5;
    localparam int SFO_SAT_CNT_WIDTH        = 16;
    localparam int SFO_SHIFT_AMT_WIDTH      = 7;

    typedef logic signed [SFO_SHIFT_AMT_WIDTH-1:0] shift_amt_t;

    // Constant term of the shift amount: +1 for the MSB position, -(out_width-1) for the output span.
    function automatic shift_amt_t sfo_shift_bias(input int out_width);
        return shift_amt_t'(2 - out_width);
    endfunction

endpackage

// File: rtl/mrr_shift_round_sat.sv
// Combinational arithmetic right shift with optional round-half-up (MRR_SFO_SHIFT_ROUND_EN)
// followed by saturation to OUT_WIDTH signed.
module mrr_shift_round_sat #(
    parameter int IN_WIDTH  = 32,
    parameter int OUT_WIDTH = 16,
    parameter int R_WIDTH   = 7
) (
    input  logic signed [IN_WIDTH-1:0]  x,
    input  logic        [R_WIDTH-1:0]   r,
    output logic signed [OUT_WIDTH-1:0] v,
    output logic                        sat
);

    localparam int EXT_PAD = IN_WIDTH - OUT_WIDTH + 2;
    localparam logic signed [IN_WIDTH:0] V_MAX = {{EXT_PAD{1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [IN_WIDTH:0] V_MIN = {{EXT_PAD{1'b1}}, {(OUT_WIDTH-1){1'b0}}};

    logic signed [IN_WIDTH:0] x_ext;
    logic signed [IN_WIDTH:0] sum;
    logic signed [IN_WIDTH:0] shifted;

`ifdef MRR_SFO_SHIFT_ROUND_EN
    localparam logic signed [IN_WIDTH:0] ONE = {{IN_WIDTH{1'b0}}, 1'b1};
    logic signed [IN_WIDTH:0] rnd;
`endif

    always_comb begin
        x_ext = {x[IN_WIDTH-1], x};
`ifdef MRR_SFO_SHIFT_ROUND_EN
        rnd = (r != '0) ? (ONE << (r - R_WIDTH'(1))) : '0;
        sum = x_ext + rnd;
`else
        sum = x_ext;
`endif
        // One extra bit of headroom keeps x + rnd from wrapping before the shift.
        shifted = sum >>> r;
        sat     = 1'b0;
        v       = shifted[OUT_WIDTH-1:0];
        if (shifted > V_MAX) begin
            v   = V_MAX[OUT_WIDTH-1:0];
            sat = 1'b1;
        end else if (shifted < V_MIN) begin
            v   = V_MIN[OUT_WIDTH-1:0];
            sat = 1'b1;
        end
    end

endmodule

// File: rtl/mrr_sfo_fft_shift_apply.sv
// Streams secondary-FFT I/Q through a per-bin rounding right-shift and saturation; 2-cycle latency.
// Backpressure: in_ready = !s1_valid || s2_adv; index held while stalled. Rounding via MRR_SFO_SHIFT_ROUND_EN.
module mrr_sfo_fft_shift_apply
    import mrr_sfo_fft_shift_apply_pkg::*;
#(
    parameter int OUT_WIDTH   = SFO_OUT_WIDTH,
    parameter int IN_WIDTH    = SFO_IN_WIDTH,
    parameter int SHIFT_WIDTH = SFO_SHIFT_WIDTH,
    parameter int IDX_WIDTH   = PRIMARY_FFT_MAX_LEN_LOG2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         clear,
    input  logic [IDX_WIDTH:0]           setting_primary_fft_len_mask,
    input  logic [2:0]                   setting_headroom,
    input  logic [IN_WIDTH-1:0]          in_i,
    input  logic [IN_WIDTH-1:0]          in_q,
    input  logic                         in_valid,
    input  logic                         in_last,
    output logic                         in_ready,
    output logic [IDX_WIDTH-1:0]         shift_idx_next,
    input  logic [SHIFT_WIDTH-1:0]       shift_in,
    output logic [OUT_WIDTH-1:0]         out_i,
    output logic [OUT_WIDTH-1:0]         out_q,
    output logic [SHIFT_WIDTH-1:0]       out_shift,
    output logic                         out_valid,
    output logic                         out_last,
    input  logic                         out_ready,
    output logic [SFO_SAT_CNT_WIDTH-1:0] sat_count
);

    localparam shift_amt_t SHIFT_BIAS = sfo_shift_bias(OUT_WIDTH);
    localparam shift_amt_t R_MAX      = shift_amt_t'(IN_WIDTH - 1);

    logic                         s1_valid_q, s1_valid_d;
    logic signed [IN_WIDTH-1:0]   s1_smp_i_q, s1_smp_i_d;
    logic signed [IN_WIDTH-1:0]   s1_smp_q_q, s1_smp_q_d;
    logic                         s1_last_q, s1_last_d;
    logic [IDX_WIDTH-1:0]         s1_idx_q, s1_idx_d;
    logic [IDX_WIDTH-1:0]         bin_idx_q, bin_idx_d;
    logic                         out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]         out_i_q, out_i_d;
    logic [OUT_WIDTH-1:0]         out_q_q, out_q_d;
    logic [SHIFT_WIDTH-1:0]       out_shift_q, out_shift_d;
    logic                         out_last_q, out_last_d;
    logic [SFO_SAT_CNT_WIDTH-1:0] sat_count_q, sat_count_d;

    logic                         s2_adv;
    logic                         accept;
    logic [IDX_WIDTH:0]           bin_idx_inc;
    shift_amt_t                   shift_in_s;
    shift_amt_t                   headroom_s;
    shift_amt_t                   r_raw;
    shift_amt_t                   r_clamped;
    logic [SFO_SHIFT_AMT_WIDTH-1:0] r_amt;
    logic signed [OUT_WIDTH-1:0]  v_i, v_q;
    logic                         sat_i, sat_q;

    always_comb begin
        s2_adv      = !out_valid_q || out_ready;
        in_ready    = !clear && (!s1_valid_q || s2_adv);
        accept      = in_valid && in_ready;
        // Normalization sees the index of the beat now entering S1, else the one parked in S1.
        shift_idx_next = accept ? bin_idx_q : s1_idx_q;
        bin_idx_inc = ({1'b0, bin_idx_q} + (IDX_WIDTH+1)'(1)) & setting_primary_fft_len_mask;
    end

    always_comb begin
        shift_in_s = shift_amt_t'({{(SFO_SHIFT_AMT_WIDTH-SHIFT_WIDTH){1'b0}}, shift_in});
        headroom_s = shift_amt_t'({{(SFO_SHIFT_AMT_WIDTH-3){1'b0}}, setting_headroom});
        r_raw      = shift_in_s + headroom_s + SHIFT_BIAS;
        r_clamped  = r_raw;
        if (r_raw < shift_amt_t'(0)) begin
            r_clamped = '0;
        end else if (r_raw > R_MAX) begin
            r_clamped = R_MAX;
        end
        r_amt = $unsigned(r_clamped);
    end

    mrr_shift_round_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .R_WIDTH   (SFO_SHIFT_AMT_WIDTH)
    ) u_round_sat_i (
        .x   (s1_smp_i_q),
        .r   (r_amt),
        .v   (v_i),
        .sat (sat_i)
    );

    mrr_shift_round_sat #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .R_WIDTH   (SFO_SHIFT_AMT_WIDTH)
    ) u_round_sat_q (
        .x   (s1_smp_q_q),
        .r   (r_amt),
        .v   (v_q),
        .sat (sat_q)
    );

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_smp_i_d  = s1_smp_i_q;
        s1_smp_q_d  = s1_smp_q_q;
        s1_last_d   = s1_last_q;
        s1_idx_d    = s1_idx_q;
        bin_idx_d   = bin_idx_q;
        out_valid_d = out_valid_q;
        out_i_d     = out_i_q;
        out_q_d     = out_q_q;
        out_shift_d = out_shift_q;
        out_last_d  = out_last_q;
        sat_count_d = sat_count_q;

        if (clear) begin
            s1_valid_d  = 1'b0;
            s1_idx_d    = '0;
            bin_idx_d   = '0;
            out_valid_d = 1'b0;
            sat_count_d = '0;
        end else begin
            if (accept) begin
                s1_valid_d = 1'b1;
                s1_smp_i_d = $signed(in_i);
                s1_smp_q_d = $signed(in_q);
                s1_last_d  = in_last;
                s1_idx_d   = bin_idx_q;
                bin_idx_d  = in_last ? '0 : bin_idx_inc[IDX_WIDTH-1:0];
            end else if (s2_adv) begin
                s1_valid_d = 1'b0;
            end

            if (s2_adv) begin
                out_valid_d = s1_valid_q;
                if (s1_valid_q) begin
                    out_i_d     = v_i;
                    out_q_d     = v_q;
                    out_shift_d = r_amt[SHIFT_WIDTH-1:0];
                    out_last_d  = s1_last_q;
                    if ((sat_i || sat_q) && (sat_count_q != '1)) begin
                        sat_count_d = sat_count_q + 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_smp_i_q  <= '0;
            s1_smp_q_q  <= '0;
            s1_last_q   <= 1'b0;
            s1_idx_q    <= '0;
            bin_idx_q   <= '0;
            out_valid_q <= 1'b0;
            out_i_q     <= '0;
            out_q_q     <= '0;
            out_shift_q <= '0;
            out_last_q  <= 1'b0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_smp_i_q  <= s1_smp_i_d;
            s1_smp_q_q  <= s1_smp_q_d;
            s1_last_q   <= s1_last_d;
            s1_idx_q    <= s1_idx_d;
            bin_idx_q   <= bin_idx_d;
            out_valid_q <= out_valid_d;
            out_i_q     <= out_i_d;
            out_q_q     <= out_q_d;
            out_shift_q <= out_shift_d;
            out_last_q  <= out_last_d;
            sat_count_q <= sat_count_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_i     = out_i_q;
    assign out_q     = out_q_q;
    assign out_shift = out_shift_q;
    assign out_last  = out_last_q;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_mrr_sfo_fft_shift_apply.sv
// Bench for mrr_sfo_fft_shift_apply: directed cases plus randomized streaming against a
// floor-division reference model; honours MRR_SFO_SHIFT_ROUND_EN for the rounding expectation.
module tb_mrr_sfo_fft_shift_apply;
    import mrr_sfo_fft_shift_apply_pkg::*;

    localparam int XW = PRIMARY_FFT_MAX_LEN_LOG2;

    logic        clk;
    logic        rst_n;
    logic        clear;
    logic [XW:0] setting_primary_fft_len_mask;
    logic [2:0]  setting_headroom;
    logic [31:0] in_i, in_q;
    logic        in_valid, in_last, in_ready;
    logic [XW-1:0] shift_idx_next;
    logic [4:0]  shift_in;
    logic [15:0] out_i, out_q;
    logic [4:0]  out_shift;
    logic        out_valid, out_last, out_ready;
    logic [15:0] sat_count;

    mrr_sfo_fft_shift_apply dut (
        .clk                          (clk),
        .rst_n                        (rst_n),
        .clear                        (clear),
        .setting_primary_fft_len_mask (setting_primary_fft_len_mask),
        .setting_headroom             (setting_headroom),
        .in_i                         (in_i),
        .in_q                         (in_q),
        .in_valid                     (in_valid),
        .in_last                      (in_last),
        .in_ready                     (in_ready),
        .shift_idx_next               (shift_idx_next),
        .shift_in                     (shift_in),
        .out_i                        (out_i),
        .out_q                        (out_q),
        .out_shift                    (out_shift),
        .out_valid                    (out_valid),
        .out_last                     (out_last),
        .out_ready                    (out_ready),
        .sat_count                    (sat_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Normalization block model: one-cycle lookup of the presented bin index.
    logic [4:0] lut [0:(1<<XW)-1];
    always @(posedge clk) shift_in <= lut[shift_idx_next];

    typedef struct {
        logic [15:0] i;
        logic [15:0] q;
        logic [4:0]  sh;
        logic        last;
        bit          sat;
    } exp_t;

    exp_t        exp_q[$];
    int          n_chk = 0;
    int          n_err = 0;
    int          m_bin, m_last_idx, m_sat, hr;
    logic [XW:0] mask;
    bit          last_rdy;
    logic [15:0] last_out_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // floor((x + rnd) / 2^r), then clamp to int16
    task automatic ref_sample(input int x, input int r, output logic [15:0] v, output bit s);
        longint t, p, fl;
        t = longint'(x);
        p = 64'sd1 <<< r;
`ifdef MRR_SFO_SHIFT_ROUND_EN
        if (r > 0) t = t + p / 2;
`endif
        fl = t / p;
        if ((t % p != 0) && (t < 0)) fl = fl - 1;
        s = 1'b0;
        if (fl > 32767) begin
            fl = 32767;
            s  = 1'b1;
        end else if (fl < -32768) begin
            fl = -32768;
            s  = 1'b1;
        end
        v = fl[15:0];
    endtask

    task automatic set_cfg(input int h, input logic [XW:0] m);
        hr = h;
        mask = m;
        setting_headroom = h[2:0];
        setting_primary_fft_len_mask = m;
    endtask

    task automatic step(input bit v, input logic [31:0] di, input logic [31:0] dq,
                        input bit dl, input bit ordy, input bit clr);
        exp_t e;
        bit acc, si, sq;
        int r;
        logic [15:0] vi, vq;
        in_valid  = v;
        in_i      = di;
        in_q      = dq;
        in_last   = dl;
        clear     = clr;
        out_ready = clr ? 1'b0 : ordy;
        @(negedge clk);
        last_rdy = in_ready;
        if (clr) chk("clear_in_ready", {31'd0, in_ready}, 32'd0);
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("out_i", {16'd0, out_i}, {16'd0, e.i});
                chk("out_q", {16'd0, out_q}, {16'd0, e.q});
                chk("out_shift", {27'd0, out_shift}, {27'd0, e.sh});
                chk("out_last", {31'd0, out_last}, {31'd0, e.last});
                if (e.sat && m_sat < 65535) m_sat++;
                chk("sat_count", {16'd0, sat_count}, m_sat);
                last_out_i = out_i;
            end
        end
        acc = in_valid && in_ready;
        chk("shift_idx_next", {{(32-XW){1'b0}}, shift_idx_next}, acc ? m_bin : m_last_idx);
        if (acc) begin
            r = int'(lut[m_bin]) + 1 + hr - 15;
            if (r < 0) r = 0;
            if (r > 31) r = 31;
            ref_sample(int'(di), r, vi, si);
            ref_sample(int'(dq), r, vq, sq);
            e.i = vi;
            e.q = vq;
            e.sh = r[4:0];
            e.last = dl;
            e.sat = si || sq;
            exp_q.push_back(e);
            m_last_idx = m_bin;
            m_bin = dl ? 0 : ((m_bin + 1) & int'(mask));
        end
        @(posedge clk);
        #1;
        if (clr) begin
            exp_q.delete();
            m_bin = 0;
            m_last_idx = 0;
            m_sat = 0;
        end
        clear = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 20; k++) begin
            if (exp_q.size() == 0) break;
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        end
        chk("drain_left", exp_q.size(), 32'd0);
    endtask

    task automatic do_clear();
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        in_valid = 1'b0;
    endtask

    function automatic logic [31:0] rand_smp();
        logic [31:0] d;
        if ($urandom_range(0, 2) == 0) d = $urandom;
        else d = 32'($urandom_range(0, 200000));
        if ($urandom_range(0, 1) == 1) d = 32'(-int'(d));
        return d;
    endfunction

    initial begin
        rst_n = 1'b0;
        clear = 1'b0;
        in_valid = 1'b0;
        in_last = 1'b0;
        in_i = '0;
        in_q = '0;
        out_ready = 1'b1;
        m_bin = 0;
        m_last_idx = 0;
        m_sat = 0;
        last_out_i = '0;
        set_cfg(0, 11'h3FF);
        for (int k = 0; k < (1 << XW); k++) lut[k] = 5'd16;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_i", {16'd0, out_i}, 32'd0);
        chk("rst_out_q", {16'd0, out_q}, 32'd0);
        chk("rst_out_shift", {27'd0, out_shift}, 32'd0);
        chk("rst_out_last", {31'd0, out_last}, 32'd0);
        chk("rst_sat_count", {16'd0, sat_count}, 32'd0);
        chk("rst_idx", {{(32-XW){1'b0}}, shift_idx_next}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Case 1: r=2 rounding and 2-cycle latency
        step(1'b1, 32'h0001_2345, 32'hFFFE_DCBB, 1'b0, 1'b1, 1'b0);
        chk("lat_c1", {31'd0, out_valid}, 32'd0);
        step(1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        chk("lat_c2", {31'd0, out_valid}, 32'd1);
        chk("t1_out_i", {16'd0, out_i}, 32'h48D1);
        drain();
        chk("t1_sat", {16'd0, sat_count}, 32'd0);

        // Case 2: 8 bins, mask 7, shift_in = idx+14 gives out_shift = idx
        do_clear();
        set_cfg(0, 11'h007);
        for (int k = 0; k < 8; k++) lut[k] = 5'(k + 14);
        for (int k = 0; k < 16; k++)
            step(1'b1, rand_smp(), rand_smp(), (k == 7), 1'b1, 1'b0);
        drain();

        // Case 3: saturation both directions
        do_clear();
        set_cfg(0, 11'h3FF);
        for (int k = 0; k < (1 << XW); k++) lut[k] = 5'd20;
        step(1'b1, 32'h7FFF_FFFF, 32'd0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("t3_pos_sat", {16'd0, last_out_i}, 32'h7FFF);
        step(1'b1, 32'h8000_0000, 32'd0, 1'b0, 1'b1, 1'b0);
        drain();
        chk("t3_neg_sat", {16'd0, last_out_i}, 32'h8000);
        chk("t3_sat_count", {16'd0, sat_count}, 32'd2);

        // Case 6: truncation versus rounding on a small value
        for (int k = 0; k < (1 << XW); k++) lut[k] = 5'd16;
        step(1'b1, 32'd6, 32'd0, 1'b0, 1'b1, 1'b0);
        drain();
`ifdef MRR_SFO_SHIFT_ROUND_EN
        chk("t6_small", {16'd0, last_out_i}, 32'h0002);
`else
        chk("t6_small", {16'd0, last_out_i}, 32'h0001);
`endif

        // Case 4: out_ready low 5 cycles mid-stream
        for (int k = 0; k < (1 << XW); k++) lut[k] = 5'($urandom_range(0, 31));
        for (int k = 0; k < 3; k++) step(1'b1, rand_smp(), rand_smp(), 1'b0, 1'b1, 1'b0);
        for (int k = 0; k < 5; k++) step(1'b1, rand_smp(), rand_smp(), 1'b0, 1'b0, 1'b0);
        chk("bp_in_ready", {31'd0, last_rdy}, 32'd0);
        for (int k = 0; k < 4; k++) step(1'b1, rand_smp(), rand_smp(), 1'b0, 1'b1, 1'b0);
        drain();

        // Case 5: clear with S1 and S2 full
        for (int k = 0; k < 3; k++) step(1'b1, rand_smp(), rand_smp(), 1'b0, 1'b0, 1'b0);
        do_clear();
        chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
        chk("clr_sat", {16'd0, sat_count}, 32'd0);
        chk("clr_idx", {{(32-XW){1'b0}}, shift_idx_next}, 32'd0);
        step(1'b1, rand_smp(), rand_smp(), 1'b0, 1'b1, 1'b0);
        drain();

        // Randomized streaming with varying settings
        for (int rnd = 0; rnd < 4; rnd++) begin
            logic [XW:0] masks [4];
            masks[0] = 11'h007;
            masks[1] = 11'h01F;
            masks[2] = 11'h0FF;
            masks[3] = 11'h3FF;
            do_clear();
            set_cfg($urandom_range(0, 7), masks[rnd]);
            for (int k = 0; k < (1 << XW); k++) lut[k] = 5'($urandom_range(0, 31));
            for (int c = 0; c < 400; c++)
                step(($urandom_range(0, 9) < 7), rand_smp(), rand_smp(),
                     ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), 1'b0);
            drain();
        end

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
